// File: rtl/bus_ctrl.sv
// rtl/bus_ctrl.sv - single-master bus controller decoding CPU accesses to RAM, VRAM and IO slaves
module bus_ctrl #(
    parameter int          RAM_AW  = 12,
    parameter int          VRAM_AW = 16,
    parameter int          IO_AW   = 4,
    parameter logic [15:0] VRAM_HI = 16'hF000,
    parameter logic [15:0] IO_HI   = 16'hF001,
    parameter int          TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [31:0]        cpu_addr,
    input  logic [31:0]        cpu_wdata,
    output logic [31:0]        cpu_rdata,
    output logic               cpu_ready,
    output logic               cpu_err,
    output logic               busy,
    output logic               ram_stb,
    output logic               ram_we,
    output logic [RAM_AW-1:0]  ram_addr,
    output logic [31:0]        ram_wdata,
    input  logic [31:0]        ram_rdata,
    input  logic               ram_ack,
    output logic               vram_stb,
    output logic               vram_we,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_wdata,
    input  logic [7:0]         vram_rdata,
    input  logic               vram_ack,
    output logic               io_stb,
    output logic               io_we,
    output logic [IO_AW-1:0]   io_addr,
    output logic [31:0]        io_wdata,
    input  logic [31:0]        io_rdata,
    input  logic               io_ack,
    output logic [7:0]         err_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int              TO_W    = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state;
    state_t          state_next;
    logic [TO_W-1:0] to_cnt;

    logic        ram_hit;
    logic        vram_hit;
    logic        io_hit;
    logic        acc_map;
    logic        acc_unmap;
    logic        done_ok;
    logic        done_to;
    logic        sel_ack;
    logic        sel_we;
    logic [31:0] sel_rdata;

    // Region decode of the incoming CPU address; RAM wins over the others.
    always_comb begin
        ram_hit  = (cpu_addr[31:RAM_AW+2] == '0);
        vram_hit = !ram_hit && (cpu_addr[31:16] == VRAM_HI);
        io_hit   = !ram_hit && !vram_hit && (cpu_addr[31:16] == IO_HI);
    end

    // The live strobe identifies the selected slave, so acks and read data from the others are masked out.
    always_comb begin
        sel_ack   = (ram_stb & ram_ack) | (vram_stb & vram_ack) | (io_stb & io_ack);
        sel_we    = ram_we | vram_we | io_we;
        sel_rdata = 32'd0;
        if (ram_stb) begin
            sel_rdata = ram_rdata;
        end else if (vram_stb) begin
            sel_rdata = {24'd0, vram_rdata};
        end else if (io_stb) begin
            sel_rdata = io_rdata;
        end
    end

    // Next-state logic; an ack in the last allowed cycle beats the timeout.
    always_comb begin
        state_next = state;
        acc_map    = 1'b0;
        acc_unmap  = 1'b0;
        done_ok    = 1'b0;
        done_to    = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (ram_hit || vram_hit || io_hit) begin
                        acc_map    = 1'b1;
                        state_next = ACCESS;
                    end else begin
                        acc_unmap  = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            ACCESS: begin
                if (sel_ack) begin
                    done_ok    = 1'b1;
                    state_next = RESP;
                end else if (to_cnt == TO_LAST) begin
                    done_to    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Slave-side strobe, direction, address and data; launched on accept, held through ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_stb    <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            vram_stb   <= 1'b0;
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            vram_wdata <= '0;
            io_stb     <= 1'b0;
            io_we      <= 1'b0;
            io_addr    <= '0;
            io_wdata   <= '0;
        end else if (acc_map) begin
            if (ram_hit) begin
                ram_stb   <= 1'b1;
                ram_we    <= cpu_we;
                ram_addr  <= cpu_addr[RAM_AW+1:2];
                ram_wdata <= cpu_wdata;
            end else if (vram_hit) begin
                vram_stb   <= 1'b1;
                vram_we    <= cpu_we;
                vram_addr  <= cpu_addr[VRAM_AW-1:0];
                vram_wdata <= cpu_wdata[7:0];
            end else begin
                io_stb   <= 1'b1;
                io_we    <= cpu_we;
                io_addr  <= cpu_addr[IO_AW+1:2];
                io_wdata <= cpu_wdata;
            end
        end else if (done_ok || done_to) begin
            ram_stb  <= 1'b0;
            ram_we   <= 1'b0;
            vram_stb <= 1'b0;
            vram_we  <= 1'b0;
            io_stb   <= 1'b0;
            io_we    <= 1'b0;
        end
    end

    // Wait-cycle counter: zeroed on accept, advances on every ACCESS cycle that sees no ack.
    always_ff @(posedge clk) begin
        if (rst || acc_map) begin
            to_cnt <= '0;
        end else if (state == ACCESS && !sel_ack) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // CPU response: ready pulses for the single RESP cycle; data and error persist until the next RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
        end else begin
            cpu_ready <= (state_next == RESP);
            if (done_ok) begin
                cpu_rdata <= sel_we ? 32'd0 : sel_rdata;
                cpu_err   <= 1'b0;
            end else if (done_to || acc_unmap) begin
                cpu_rdata <= 32'd0;
                cpu_err   <= 1'b1;
            end
        end
    end

    // Saturating bus-error counter, updated together with the erroring response.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 8'd0;
        end else if ((done_to || acc_unmap) && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_bus_ctrl.sv
// tb/tb_bus_ctrl.sv - directed self-checking bench for bus_ctrl
module tb_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;
    logic        busy;
    logic        ram_stb;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic        ram_ack = 1'b0;
    logic        vram_stb;
    logic        vram_we;
    logic [15:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata = '0;
    logic        vram_ack = 1'b0;
    logic        io_stb;
    logic        io_we;
    logic [3:0]  io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata = '0;
    logic        io_ack = 1'b0;
    logic [7:0]  err_cnt;

    int vectors = 0;
    int miscompares = 0;

    bus_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .cpu_err    (cpu_err),
        .busy       (busy),
        .ram_stb    (ram_stb),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .ram_ack    (ram_ack),
        .vram_stb   (vram_stb),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_rdata (vram_rdata),
        .vram_ack   (vram_ack),
        .io_stb     (io_stb),
        .io_we      (io_we),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .io_ack     (io_ack),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int pulses;
        int adjacent;
        logic prev_ready;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cpu_ready), 32'd0);
        chk("rst_stbs", {29'd0, ram_stb, vram_stb, io_stb}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);

        // RAM read, ack in first strobe cycle (ack already high in IDLE is ignored)
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
        ram_rdata = 32'hDEAD_BEEF; ram_ack = 1'b1;
        tick();
        cpu_req = 1'b0;
        chk("ram_stb_on", 32'(ram_stb), 32'd1);
        chk("ram_addr", 32'(ram_addr), 32'd4);
        chk("ram_busy", 32'(busy), 32'd1);
        chk("ram_ready_early", 32'(cpu_ready), 32'd0);
        tick();
        ram_ack = 1'b0;
        chk("ram_stb_off", 32'(ram_stb), 32'd0);
        chk("ram_ready", 32'(cpu_ready), 32'd1);
        chk("ram_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("ram_err", 32'(cpu_err), 32'd0);
        tick();
        chk("ram_ready_pulse", 32'(cpu_ready), 32'd0);
        chk("ram_idle", 32'(busy), 32'd0);

        // VRAM write, ack in third strobe cycle; RAM ack meanwhile must be ignored
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hF000_0123; cpu_wdata = 32'h0000_00A5;
        vram_rdata = 8'h77;
        tick();
        cpu_req = 1'b0; ram_ack = 1'b1;
        chk("vram_sig1", {vram_stb, vram_we, vram_addr, vram_wdata}, {1'b1, 1'b1, 16'h0123, 8'hA5} );
        chk("vram_others_off", {30'd0, ram_stb, io_stb}, 32'd0);
        tick();
        chk("vram_sig2", {vram_stb, vram_we, vram_addr, vram_wdata}, {1'b1, 1'b1, 16'h0123, 8'hA5} );
        tick();
        chk("vram_sig3", {vram_stb, vram_we, vram_addr, vram_wdata}, {1'b1, 1'b1, 16'h0123, 8'hA5} );
        vram_ack = 1'b1;
        tick();
        vram_ack = 1'b0; ram_ack = 1'b0;
        chk("vram_ready", 32'(cpu_ready), 32'd1);
        chk("vram_err", 32'(cpu_err), 32'd0);
        chk("vram_wr_rdata", cpu_rdata, 32'd0);
        chk("vram_stb_off", 32'(vram_stb), 32'd0);
        tick();

        // IO read timeout
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hF001_0008; io_rdata = 32'h1234_5678;
        tick();
        cpu_req = 1'b0;
        chk("io_addr", 32'(io_addr), 32'd2);
        n = 0;
        for (int i = 0; i < 40 && !cpu_ready; i++) begin
            if (io_stb) n++;
            tick();
        end
        chk("to_stb_cycles", 32'(n), 32'd16);
        chk("to_ready", 32'(cpu_ready), 32'd1);
        chk("to_err", 32'(cpu_err), 32'd1);
        chk("to_rdata", cpu_rdata, 32'd0);
        chk("to_err_cnt", 32'(err_cnt), 32'd1);
        tick();
        chk("to_err_hold", 32'(cpu_err), 32'd1);

        // IO read with ack arriving in the 16th strobe cycle
        cpu_req = 1'b1; io_rdata = 32'hCAFE_0001;
        tick();
        cpu_req = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("late_stb", 32'(io_stb), 32'd1);
        io_ack = 1'b1;
        tick();
        io_ack = 1'b0;
        chk("late_ready", 32'(cpu_ready), 32'd1);
        chk("late_err", 32'(cpu_err), 32'd0);
        chk("late_rdata", cpu_rdata, 32'hCAFE_0001);
        chk("late_err_cnt", 32'(err_cnt), 32'd1);
        tick();

        // Unmapped single access: response one cycle after accept, no strobe
        cpu_req = 1'b1; cpu_addr = 32'h8000_0000;
        tick();
        cpu_req = 1'b0;
        chk("unmap_ready", 32'(cpu_ready), 32'd1);
        chk("unmap_err", 32'(cpu_err), 32'd1);
        chk("unmap_stbs", {29'd0, ram_stb, vram_stb, io_stb}, 32'd0);
        chk("unmap_err_cnt", 32'(err_cnt), 32'd2);
        tick();

        // 300 back-to-back unmapped accesses with req held high
        cpu_req = 1'b1;
        pulses = 0; adjacent = 0; prev_ready = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (cpu_ready) pulses++;
            if (cpu_ready && prev_ready) adjacent++;
            prev_ready = cpu_ready;
        end
        cpu_req = 1'b0;
        chk("b2b_pulses", 32'(pulses), 32'd300);
        chk("b2b_adjacent", 32'(adjacent), 32'd0);
        chk("sat_err_cnt", 32'(err_cnt), 32'd255);
        tick();

        // Reset in the second ACCESS cycle of a RAM read, with ack coinciding
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040; ram_rdata = 32'h1111_2222;
        tick();
        cpu_req = 1'b0;
        tick();
        rst = 1'b1; ram_ack = 1'b1;
        tick();
        rst = 1'b0; ram_ack = 1'b0;
        chk("rst_mid_outs", {25'd0, ram_stb, ram_we, cpu_ready, cpu_err, busy, vram_stb, io_stb}, 32'd0);
        chk("rst_mid_addr", 32'(ram_addr), 32'd0);
        chk("rst_mid_rdata", cpu_rdata, 32'd0);
        chk("rst_mid_err_cnt", 32'(err_cnt), 32'd0);
        tick();
        chk("rst_mid_no_ready", 32'(cpu_ready), 32'd0);

        // Request after reset completes normally
        cpu_req = 1'b1; cpu_addr = 32'h0000_0020; ram_rdata = 32'h0BAD_F00D; ram_ack = 1'b1;
        tick();
        cpu_req = 1'b0;
        chk("post_rst_addr", 32'(ram_addr), 32'd8);
        tick();
        ram_ack = 1'b0;
        chk("post_rst_ready", 32'(cpu_ready), 32'd1);
        chk("post_rst_rdata", cpu_rdata, 32'h0BAD_F00D);
        chk("post_rst_err", 32'(cpu_err), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
